tile_scheduler: RTL and testbench

- Sequences one decoded layer into a stream of tile commands for the PE array / GLB DMA.
- Sits directly downstream of the layer decoder registers and upstream of the tile-level DMA and PE controller.
- Walks the output-channel (K), output-pixel (N) and input-channel (D) tile loops.
- Issues one command per tile over a valid/ready handshake, waits for tile completion, then signals layer completion.

---
 rtl/tile_scheduler_pkg.sv | 46 ++++
 rtl/tile_scheduler_loop_ctr.sv | 60 ++++++
 rtl/tile_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_tile_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_scheduler_pkg.sv
// Shared scheduler types: layer kinds, FSM states, tile command layout and the
// ceiling-divide helper used once per layer to size the loop nest.
package tile_scheduler_pkg;

  localparam int CH_W = 11;
  localparam int TS_W = 7;
  localparam int N_W  = 16;

  typedef enum logic [1:0] {
    LT_PW  = 2'd0,
    LT_DW  = 2'd1,
    LT_STD = 2'd2,
    LT_LIN = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [TS_W-1:0] k_idx;
    logic [TS_W-1:0] d_idx;
    logic [N_W-1:0]  n_base;
    logic [TS_W-1:0] cur_K;
    logic [TS_W-1:0] cur_D;
    logic [N_W-1:0]  cur_n;
    logic            first_d;
    logic            last_d;
  } tile_cmd_t;

  // One extra bit keeps num + den - 1 from wrapping for large pixel counts.
  function automatic logic [N_W-1:0] ceil_div(input logic [N_W-1:0] num,
                                              input logic [N_W-1:0] den);
    logic [N_W:0] sum;
    sum = {1'b0, num} + {1'b0, den} - {{N_W{1'b0}}, 1'b1};
    if (den == '0) begin
      return '0;
    end
    return N_W'(sum / {1'b0, den});
  endfunction

endpackage

// File: rtl/tile_scheduler_loop_ctr.sv
// One level of the tile loop nest: index, running offset, partial-tile clamp.
// idx_o/off_o/cur_o show the values after this cycle's clear/step; wrap_o is current.
module tile_loop_ctr #(
  parameter int IW = 7,
  parameter int W  = 11,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_i,
  input  logic [W-1:0]  total_i,
  input  logic [CW-1:0] tile_i,
  input  logic [IW-1:0] cnt_i,
  output logic [IW-1:0] idx_o,
  output logic [W-1:0]  off_o,
  output logic [CW-1:0] cur_o,
  output logic          wrap_o
);

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  off_q, off_d;
  logic [W-1:0]  rem;

  assign wrap_o = (idx_q == cnt_i - IW'(1));

  always_comb begin
    idx_d = idx_q;
    off_d = off_q;
    if (clr_i) begin
      idx_d = '0;
      off_d = '0;
    end else if (step_i) begin
      if (wrap_o) begin
        idx_d = '0;
        off_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
        off_d = off_q + W'(tile_i);
      end
    end
  end

  // The last tile of a level takes whatever remains past the running offset.
  assign rem   = total_i - off_d;
  assign cur_o = (rem < W'(tile_i)) ? rem[CW-1:0] : tile_i;
  assign idx_o = idx_d;
  assign off_o = off_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      off_q <= '0;
    end else begin
      idx_q <= idx_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks the K / N / D tile loops of one layer, issuing one command per tile over
// valid/ready and waiting for tile_done_i before advancing; pulses layer_done_o at the end.
module tile_scheduler
  import tile_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      layer_type_i,
  input  logic [CH_W-1:0] in_D_i,
  input  logic [CH_W-1:0] out_K_i,
  input  logic [TS_W-1:0] tile_D_i,
  input  logic [TS_W-1:0] tile_K_i,
  input  logic [N_W-1:0]  tile_n_i,
  input  logic [TS_W-1:0] out_R_i,
  input  logic [TS_W-1:0] out_C_i,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output logic [TS_W-1:0] k_idx_o,
  output logic [TS_W-1:0] d_idx_o,
  output logic [N_W-1:0]  n_base_o,
  output logic [TS_W-1:0] cur_K_o,
  output logic [TS_W-1:0] cur_D_o,
  output logic [N_W-1:0]  cur_n_o,
  output logic            first_d_o,
  output logic            last_d_o,
  input  logic            tile_done_i,
  output logic            busy_o,
  output logic            layer_done_o
);

  sched_state_e    state_q;
  tile_cmd_t       cmd_q, cmd_d;
  logic            cmd_vld_q, busy_q, done_q;
  layer_type_e     lt_q;
  logic [CH_W-1:0] in_D_q, out_K_q;
  logic [TS_W-1:0] tile_D_q, tile_K_q, nk_q, nd_q;
  logic [N_W-1:0]  tile_n_q, p_q, nn_q;

  logic            idle, adv, dw_in, dw_sel, zero_in, all_wrap;
  logic [N_W-1:0]  p_in, nn_in;
  logic [TS_W-1:0] nk_in, nd_in, nd_sel;
  logic [CH_W-1:0] cfg_K, cfg_D;
  logic [TS_W-1:0] cfg_tK, cfg_tD;
  logic [N_W-1:0]  cfg_tn, cfg_P;

  logic [TS_W-1:0] k_idx_n, d_idx_n, k_cur_n, d_cur_n;
  logic [CH_W-1:0] k_off_n, d_off_n;
  logic [N_W-1:0]  n_idx_n, n_off_n, n_cur_n;
  logic            k_wrap, d_wrap, n_wrap;
  logic            unused_ok;

  assign idle  = (state_q == S_IDLE);
  assign adv   = (state_q == S_ADV);
  assign dw_in = (layer_type_i == LT_DW);

  // Loop sizing happens only on the start path; the issue path never divides.
  assign p_in    = N_W'(out_R_i) * N_W'(out_C_i);
  assign nk_in   = TS_W'(ceil_div(N_W'(out_K_i), N_W'(tile_K_i)));
  assign nd_in   = dw_in ? TS_W'(1) : TS_W'(ceil_div(N_W'(in_D_i), N_W'(tile_D_i)));
  assign nn_in   = ceil_div(p_in, tile_n_i);
  assign zero_in = (out_K_i == '0) || (in_D_i == '0) || (tile_K_i == '0) ||
                   (tile_D_i == '0) || (tile_n_i == '0) || (p_in == '0);

  // The first command is built straight from the inputs in the start cycle.
  assign cfg_K  = idle ? out_K_i  : out_K_q;
  assign cfg_D  = idle ? in_D_i   : in_D_q;
  assign cfg_tK = idle ? tile_K_i : tile_K_q;
  assign cfg_tD = idle ? tile_D_i : tile_D_q;
  assign cfg_tn = idle ? tile_n_i : tile_n_q;
  assign cfg_P  = idle ? p_in     : p_q;
  assign nd_sel = idle ? nd_in    : nd_q;
  assign dw_sel = idle ? dw_in    : (lt_q == LT_DW);

  tile_loop_ctr #(.IW(TS_W), .W(CH_W), .CW(TS_W)) u_k_loop (
    .clk(clk), .rst(rst), .clr_i(idle && start_i), .step_i(adv && d_wrap && n_wrap),
    .total_i(cfg_K), .tile_i(cfg_tK), .cnt_i(nk_q),
    .idx_o(k_idx_n), .off_o(k_off_n), .cur_o(k_cur_n), .wrap_o(k_wrap)
  );

  tile_loop_ctr #(.IW(N_W), .W(N_W), .CW(N_W)) u_n_loop (
    .clk(clk), .rst(rst), .clr_i(idle && start_i), .step_i(adv && d_wrap),
    .total_i(cfg_P), .tile_i(cfg_tn), .cnt_i(nn_q),
    .idx_o(n_idx_n), .off_o(n_off_n), .cur_o(n_cur_n), .wrap_o(n_wrap)
  );

  tile_loop_ctr #(.IW(TS_W), .W(CH_W), .CW(TS_W)) u_d_loop (
    .clk(clk), .rst(rst), .clr_i(idle && start_i), .step_i(adv),
    .total_i(cfg_D), .tile_i(cfg_tD), .cnt_i(nd_q),
    .idx_o(d_idx_n), .off_o(d_off_n), .cur_o(d_cur_n), .wrap_o(d_wrap)
  );

  assign all_wrap  = k_wrap && n_wrap && d_wrap;
  assign unused_ok = ^{k_off_n, d_off_n, n_idx_n};

  always_comb begin
    cmd_d         = '0;
    cmd_d.k_idx   = k_idx_n;
    cmd_d.d_idx   = dw_sel ? k_idx_n : d_idx_n;
    cmd_d.n_base  = n_off_n;
    cmd_d.cur_K   = k_cur_n;
    cmd_d.cur_D   = dw_sel ? k_cur_n : d_cur_n;
    cmd_d.cur_n   = n_cur_n;
    cmd_d.first_d = dw_sel || (d_idx_n == '0);
    cmd_d.last_d  = dw_sel || (d_idx_n == nd_sel - TS_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= LT_PW;
      in_D_q    <= '0;
      out_K_q   <= '0;
      tile_D_q  <= '0;
      tile_K_q  <= '0;
      tile_n_q  <= '0;
      p_q       <= '0;
      nk_q      <= '0;
      nd_q      <= '0;
      nn_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lt_q     <= layer_type_e'(layer_type_i);
            in_D_q   <= in_D_i;
            out_K_q  <= out_K_i;
            tile_D_q <= tile_D_i;
            tile_K_q <= tile_K_i;
            tile_n_q <= tile_n_i;
            p_q      <= p_in;
            nk_q     <= nk_in;
            nd_q     <= nd_in;
            nn_q     <= nn_in;
            busy_q   <= 1'b1;
            if (zero_in) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_ISSUE;
              cmd_vld_q <= 1'b1;
              cmd_q     <= cmd_d;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready_i) begin
            cmd_vld_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tile_done_i) begin
            state_q <= S_ADV;
          end
        end
        S_ADV: begin
          if (all_wrap) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_ISSUE;
            cmd_vld_q <= 1'b1;
            cmd_q     <= cmd_d;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid_o  = cmd_vld_q;
  assign k_idx_o      = cmd_q.k_idx;
  assign d_idx_o      = cmd_q.d_idx;
  assign n_base_o     = cmd_q.n_base;
  assign cur_K_o      = cmd_q.cur_K;
  assign cur_D_o      = cmd_q.cur_D;
  assign cur_n_o      = cmd_q.cur_n;
  assign first_d_o    = cmd_q.first_d;
  assign last_d_o     = cmd_q.last_d;
  assign busy_o       = busy_q;
  assign layer_done_o = done_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: a nested-loop reference model produces the expected
// command list per layer; a randomised consumer drives ready/done and stray events.
`timescale 1ns/1ps
module tb_tile_scheduler;
  import tile_scheduler_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [1:0]      layer_type_i = '0;
  logic [CH_W-1:0] in_D_i = '0, out_K_i = '0;
  logic [TS_W-1:0] tile_D_i = '0, tile_K_i = '0, out_R_i = '0, out_C_i = '0;
  logic [N_W-1:0]  tile_n_i = '0;
  logic            cmd_ready_i = 1'b0, tile_done_i = 1'b0;
  logic            cmd_valid_o, first_d_o, last_d_o, busy_o, layer_done_o;
  logic [TS_W-1:0] k_idx_o, d_idx_o, cur_K_o, cur_D_o;
  logic [N_W-1:0]  n_base_o, cur_n_o;

  tile_scheduler dut (
    .clk(clk), .rst(rst), .start_i(start_i), .layer_type_i(layer_type_i),
    .in_D_i(in_D_i), .out_K_i(out_K_i), .tile_D_i(tile_D_i), .tile_K_i(tile_K_i),
    .tile_n_i(tile_n_i), .out_R_i(out_R_i), .out_C_i(out_C_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .k_idx_o(k_idx_o), .d_idx_o(d_idx_o), .n_base_o(n_base_o),
    .cur_K_o(cur_K_o), .cur_D_o(cur_D_o), .cur_n_o(cur_n_o),
    .first_d_o(first_d_o), .last_d_o(last_d_o), .tile_done_i(tile_done_i),
    .busy_o(busy_o), .layer_done_o(layer_done_o)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int d; int nb; int ck; int cd; int cn; int fd; int ld; } cmd_t;

  cmd_t log_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int pw_k[4]   = '{0, 0, 1, 1};
  int pw_d[4]   = '{0, 1, 0, 1};
  int pw_fd[4]  = '{1, 0, 1, 0};
  int pw_ld[4]  = '{0, 1, 0, 1};
  int pt_ck[6]  = '{32, 32, 32, 8, 8, 8};
  int pt_cn[6]  = '{20, 20, 9, 20, 20, 9};
  int pt_nb[6]  = '{0, 20, 40, 0, 20, 40};
  int dw_ck[3]  = '{10, 10, 5};
  int dw_d[3]   = '{0, 1, 2};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, cmd_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_layer_done"}, layer_done_o, 0);
    check({tag, "_fields"}, {k_idx_o, d_idx_o, n_base_o, cur_K_o, cur_D_o, cur_n_o,
                             first_d_o, last_d_o}, 0);
  endtask

  task automatic run_layer(input int lt, input int K, input int D, input int tK,
                           input int tD, input int tn, input int R, input int C,
                           input int bp, input bit stray, input int abort_after);
    cmd_t exp_q[$];
    cmd_t c, o;
    int   P, nK, nD, nN, n_total, budget, cyc, done_cyc, accepted, timer, bp_left;
    bit   dw, outstanding, stalled, finished;
    dw = (lt == 1);
    P  = R * C;
    log_q.delete();
    if (K > 0 && D > 0 && tK > 0 && tD > 0 && tn > 0 && P > 0) begin
      nK = (K + tK - 1) / tK;
      nD = dw ? 1 : (D + tD - 1) / tD;
      nN = (P + tn - 1) / tn;
      for (int k = 0; k < nK; k++)
        for (int n = 0; n < nN; n++)
          for (int d = 0; d < nD; d++) begin
            c.k  = k;
            c.ck = imin(tK, K - k * tK);
            c.d  = dw ? k : d;
            c.cd = dw ? c.ck : imin(tD, D - d * tD);
            c.nb = n * tn;
            c.cn = imin(tn, P - n * tn);
            c.fd = (dw || d == 0) ? 1 : 0;
            c.ld = (dw || d == nD - 1) ? 1 : 0;
            exp_q.push_back(c);
          end
    end
    n_total = exp_q.size();
    budget  = 12 * n_total + 40 + bp;

    @(negedge clk);
    layer_type_i = 2'(lt);
    out_K_i  = CH_W'(K);
    in_D_i   = CH_W'(D);
    tile_K_i = TS_W'(tK);
    tile_D_i = TS_W'(tD);
    tile_n_i = N_W'(tn);
    out_R_i  = TS_W'(R);
    out_C_i  = TS_W'(C);
    start_i = 1'b1; cmd_ready_i = 1'b0; tile_done_i = 1'b0;
    cyc = 0; done_cyc = 0; accepted = 0; timer = 0; bp_left = bp;
    outstanding = 0; stalled = 0; finished = 0;

    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("first_valid_latency", cmd_valid_o, (n_total > 0) ? 1 : 0);
      if (stalled) check("valid_held_under_stall", cmd_valid_o, 1);
      if (exp_q.size() == 0 || outstanding) begin
        check("valid_low", cmd_valid_o, 0);
      end else if (cmd_valid_o) begin
        check("k_idx", k_idx_o, exp_q[0].k);
        check("d_idx", d_idx_o, exp_q[0].d);
        check("n_base", n_base_o, exp_q[0].nb);
        check("cur_K", cur_K_o, exp_q[0].ck);
        check("cur_D", cur_D_o, exp_q[0].cd);
        check("cur_n", cur_n_o, exp_q[0].cn);
        check("first_d", first_d_o, exp_q[0].fd);
        check("last_d", last_d_o, exp_q[0].ld);
      end

      if (layer_done_o) begin
        check("cmds_left_at_done", exp_q.size(), 0);
        check("done_latency", cyc - done_cyc, (n_total > 0) ? 2 : 1);
        check("busy_in_done", busy_o, 1);
        start_i = 1'b0; cmd_ready_i = 1'b0; tile_done_i = 1'b0;
        @(negedge clk);
        check("done_pulse_width", layer_done_o, 0);
        check("busy_after_done", busy_o, 0);
        finished = 1;
      end else begin
        check("busy_during_layer", busy_o, 1);
        if (abort_after > 0 && accepted == abort_after && outstanding) begin
          rst = 1'b1;
          #1;
          check_zero("abort_reset");
          @(negedge clk);
          check_zero("abort_hold");
          rst = 1'b0; start_i = 1'b0; cmd_ready_i = 1'b0; tile_done_i = 1'b0;
          finished = 1;
        end else begin
          start_i = 1'b0;
          tile_done_i = 1'b0;
          if (timer > 0) begin
            timer--;
            if (timer == 0) begin
              tile_done_i = 1'b1;
              done_cyc    = cyc;
              outstanding = 0;
            end
          end
          if (cmd_valid_o && bp_left > 0) begin
            cmd_ready_i = 1'b0;
            bp_left--;
          end else begin
            cmd_ready_i = stray ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
          stalled = cmd_valid_o && !cmd_ready_i;
          if (cmd_valid_o && cmd_ready_i && !outstanding && exp_q.size() > 0) begin
            o.k = k_idx_o; o.d = d_idx_o; o.nb = n_base_o; o.ck = cur_K_o;
            o.cd = cur_D_o; o.cn = cur_n_o; o.fd = first_d_o; o.ld = last_d_o;
            log_q.push_back(o);
            void'(exp_q.pop_front());
            accepted++;
            outstanding = 1;
            timer = $urandom_range(1, 3);
            if (stray && $urandom_range(0, 1) == 1) tile_done_i = 1'b1;
          end else if (stray && cmd_valid_o && $urandom_range(0, 3) == 0) begin
            tile_done_i = 1'b1;
          end
          if (stray && busy_o && $urandom_range(0, 7) == 0) begin
            start_i = 1'b1;
            layer_type_i = 2'($urandom_range(0, 3));
            out_K_i = CH_W'($urandom_range(1, 100));
            tile_K_i = TS_W'($urandom_range(1, 30));
          end
        end
      end
    end
    if (!finished) check("layer_finished_in_budget", finished, 1);
    start_i = 1'b0; cmd_ready_i = 1'b0; tile_done_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    run_layer(0, 64, 64, 32, 32, 16, 4, 4, 0, 0, 0);
    check("pw_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check("pw_k", log_q[i].k, pw_k[i]);
      check("pw_d", log_q[i].d, pw_d[i]);
      check("pw_first", log_q[i].fd, pw_fd[i]);
      check("pw_last", log_q[i].ld, pw_ld[i]);
    end

    run_layer(0, 40, 10, 32, 32, 20, 7, 7, 0, 0, 0);
    check("partial_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("partial_cur_K", log_q[i].ck, pt_ck[i]);
      check("partial_cur_n", log_q[i].cn, pt_cn[i]);
      check("partial_n_base", log_q[i].nb, pt_nb[i]);
      check("partial_cur_D", log_q[i].cd, 10);
    end

    run_layer(1, 25, 25, 10, 10, 16, 4, 4, 0, 0, 0);
    check("dw_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check("dw_cur_K", log_q[i].ck, dw_ck[i]);
      check("dw_cur_D", log_q[i].cd, dw_ck[i]);
      check("dw_d_idx", log_q[i].d, dw_d[i]);
      check("dw_first", log_q[i].fd, 1);
      check("dw_last", log_q[i].ld, 1);
    end

    run_layer(2, 20, 20, 10, 10, 8, 4, 4, 5, 0, 0);
    check("backpressure_count", log_q.size(), 8);

    run_layer(3, 30, 30, 10, 10, 9, 3, 3, 0, 1, 0);
    check("stray_count", log_q.size(), 9);

    run_layer(0, 64, 64, 32, 32, 16, 4, 4, 0, 0, 2);
    check("abort_count", log_q.size(), 2);
    run_layer(0, 64, 64, 32, 32, 16, 4, 4, 0, 0, 0);
    check("restart_count", log_q.size(), 4);
    if (log_q.size() > 0) begin
      check("restart_first_k", log_q[0].k, 0);
      check("restart_first_d", log_q[0].d, 0);
      check("restart_first_nb", log_q[0].nb, 0);
    end

    run_layer(0, 0, 64, 32, 32, 16, 4, 4, 0, 0, 0);
    check("zero_cfg_count", log_q.size(), 0);

    for (int it = 0; it < 15; it++) begin
      int K;
      K = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 48);
      run_layer($urandom_range(0, 3), K, $urandom_range(1, 48), $urandom_range(6, 24),
                $urandom_range(6, 24), $urandom_range(6, 30), $urandom_range(1, 8),
                $urandom_range(1, 8), $urandom_range(0, 3), 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
